cpu_fetch: RTL and testbench
============================

Name: cpu_fetch

Overview:
- Instruction fetch/issue unit for the single-issue LEGv8 core.
- Owns the PC and requests 32-bit words from instruction memory over a req/ack handshake.
- Presents inst[31:21] to the control decoder, which returns Branch, BranchZero and BranchNonZero.
- Resolves the next PC from those flags and the ALU zero flag; stops fetching on HALT.

Parameters:
- ADDR_W, 64, PC and imem address width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OP, 11'b11111111111, inst[31:21] pattern that halts fetch.

Ports:
- clk  in  1  core clock, all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  ADDR_W  word address (byte address, low 2 bits zero).
- imem_ack  in  1  one-cycle pulse, imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- inst_valid  out  1  inst/pc_out hold a live instruction.
- inst  out  32  current instruction; inst[31:21] drives the decoder.
- pc_out  out  ADDR_W  address of inst.
- inst_accept  in  1  execute consumes inst this cycle; branch flags and alu_zero are valid.
- branch  in  1  unconditional B, from the decoder.
- branch_zero  in  1  CBZ, from the decoder.
- branch_nonzero  in  1  CBNZ, from the decoder.
- alu_zero  in  1  ALU zero flag for the current instruction.
- halted  out  1  HALT reached; sticky until reset.

Behaviour:
- Reset:
  - Clock and reset: single clock clk; reset is synchronous and active-high.
  - Output values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, pc_out=RESET_PC, halted=0, state=S_IDLE.
- States and transitions:
  - S_IDLE: next cycle go to S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc. If imem_ack: latch rdata into inst, pc_out=pc, go to S_ISSUE. Otherwise go to S_WAIT.
  - S_WAIT: hold imem_req=1 and imem_addr. On imem_ack, latch inst, go to S_ISSUE.
  - Ack rule: minimum latency is ack in the same cycle as the first request cycle, giving inst_valid on the next cycle. imem_ack outside S_REQ/S_WAIT is ignored.
  - S_ISSUE: inst_valid=1 and imem_req=0. If inst[31:21]==HALT_OP, go to S_HALT on the next edge; inst_accept is not required. Otherwise wait for inst_accept, then set pc=next_pc and go to S_REQ; inst_valid drops on the next cycle.
  - S_HALT: halted=1, inst_valid=0, imem_req=0. Stays here; only reset exits.
- Branch resolution (sampled only when S_ISSUE and inst_accept):
  - taken = branch | (branch_zero & alu_zero) | (branch_nonzero & ~alu_zero).
  - Offset: branch=1 uses sext(inst[25:0]); otherwise sext(inst[23:5]). Both are sign-extended to ADDR_W, then shifted left by 2.
  - next_pc = taken ? pc_out + offset : pc_out + 4.
  - All addition is modulo 2^ADDR_W; wrap-around is silent.
  - If more than one flag is set, branch wins for offset selection. taken is still the OR above.
- Boundaries:
  - inst_accept outside S_ISSUE is ignored.
  - reset in any state, including mid-S_WAIT, wins: imem_req drops the next cycle and the pending ack is discarded.
  - A branch to itself (offset 0) refetches the same pc.

Decomposition:
- Package cpu_pkg holds:
  - fetch state enum: S_IDLE, S_REQ, S_WAIT, S_ISSUE, S_HALT;
  - HALT_OP;
  - OP_B/OP_CB field-position constants: imm26 [25:0], imm19 [23:5].
- One combinational sub-module, cpu_branch_target: inputs inst, pc_out and the three flags plus alu_zero; outputs next_pc.

Test Plan:
- Reset, then ack in the same cycle as req, word 0x8B020020 (ADD): imem_addr=0, inst_valid next cycle; accept with flags 0 gives next imem_addr=4.
- Ack delayed 3 cycles: imem_req and imem_addr=4 stay stable through S_WAIT; inst latched only on ack; spurious ack while in S_ISSUE is ignored.
- At pc=0x10, B with imm26=0x3FFFFFE (-2), branch=1, accept: next imem_addr=0x08.
- At pc=0x20, CBZ with imm19=3:
  - alu_zero=1 gives next addr 0x2C;
  - alu_zero=0 gives 0x24;
  - CBNZ variant gives the opposite addresses.
- Fetch 0xFFE00000 (HALT): halted=1 on the next cycle, imem_req stays 0 for 20 cycles, inst_valid=0.
- reset asserted during S_WAIT at pc=0x40, ack arrives the cycle after: outputs return to reset values, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 fetch/issue unit.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } fetch_state_e;

  localparam logic [10:0] HALT_OP = 11'b11111111111;

  // Immediate field positions for OP_B (imm26) and OP_CB (imm19) encodings.
  localparam int unsigned IMM26_MSB = 25;
  localparam int unsigned IMM26_LSB = 0;
  localparam int unsigned IMM19_MSB = 23;
  localparam int unsigned IMM19_LSB = 5;

endpackage

// File: rtl/cpu_branch_target.sv
// Next-PC resolution: sequential PC+4 or PC-relative B/CBZ/CBNZ target.
module cpu_branch_target
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [31:0]       inst,
  input  logic [ADDR_W-1:0] pc_out,
  input  logic              branch,
  input  logic              branch_zero,
  input  logic              branch_nonzero,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] next_pc
);

  localparam int unsigned Imm26W = IMM26_MSB - IMM26_LSB + 1;
  localparam int unsigned Imm19W = IMM19_MSB - IMM19_LSB + 1;

  logic [Imm26W-1:0] imm26;
  logic [Imm19W-1:0] imm19;
  logic [ADDR_W-1:0] offset;
  logic              taken;
  logic              unused_inst;

  assign imm26       = inst[IMM26_MSB:IMM26_LSB];
  assign imm19       = inst[IMM19_MSB:IMM19_LSB];
  assign unused_inst = ^{inst[31:26], inst[4:0]};

  always_comb begin
    taken = branch | (branch_zero & alu_zero) | (branch_nonzero & ~alu_zero);
    // Unconditional B takes precedence for the immediate even if CB flags are also set.
    if (branch) begin
      offset = {{(ADDR_W - Imm26W){imm26[Imm26W-1]}}, imm26} << 2;
    end else begin
      offset = {{(ADDR_W - Imm19W){imm19[Imm19W-1]}}, imm19} << 2;
    end
    next_pc = taken ? (pc_out + offset) : (pc_out + ADDR_W'(4));
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch/issue: owns the PC, handshakes with imem, halts on HALT_OP.
module cpu_fetch #(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [10:0]       HALT_OP  = cpu_pkg::HALT_OP
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              inst_accept,
  input  logic              branch,
  input  logic              branch_zero,
  input  logic              branch_nonzero,
  input  logic              alu_zero,
  output logic              halted
);
  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [31:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              req_q, req_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] next_pc;

  cpu_branch_target #(
    .ADDR_W(ADDR_W)
  ) u_branch_target (
    .inst          (inst_q),
    .pc_out        (pc_out_q),
    .branch        (branch),
    .branch_zero   (branch_zero),
    .branch_nonzero(branch_nonzero),
    .alu_zero      (alu_zero),
    .next_pc       (next_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_out_d     = pc_out_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    req_d        = req_q;
    halted_d     = halted_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        req_d   = 1'b1;
      end
      S_REQ, S_WAIT: begin
        if (imem_ack) begin
          inst_d       = imem_rdata;
          pc_out_d     = pc_q;
          inst_valid_d = 1'b1;
          req_d        = 1'b0;
          state_d      = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ISSUE: begin
        // HALT retires without waiting for execute to accept it.
        if (inst_q[31:21] == HALT_OP) begin
          inst_valid_d = 1'b0;
          halted_d     = 1'b1;
          state_d      = S_HALT;
        end else if (inst_accept) begin
          pc_d         = next_pc;
          inst_valid_d = 1'b0;
          req_d        = 1'b1;
          state_d      = S_REQ;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      pc_out_q     <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      req_q        <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_out_q     <= pc_out_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      req_q        <= req_d;
      halted_q     <= halted_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign pc_out     = pc_out_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Scoreboard bench for cpu_fetch: expected fetch addresses and issued words are queued on stimulus.
module tb_cpu_fetch;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] word;
  } fetch_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc_out;
  logic        inst_accept;
  logic        branch;
  logic        branch_zero;
  logic        branch_nonzero;
  logic        alu_zero;
  logic        halted;

  int total = 0;
  int bad   = 0;

  fetch_t      sb_q[$];
  logic [63:0] exp_addr_q[$];

  always #5 clk = ~clk;

  cpu_fetch #(
    .ADDR_W  (64),
    .RESET_PC(64'h0),
    .HALT_OP (11'h7FF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .pc_out        (pc_out),
    .inst_accept   (inst_accept),
    .branch        (branch),
    .branch_zero   (branch_zero),
    .branch_nonzero(branch_nonzero),
    .alu_zero      (alu_zero),
    .halted        (halted)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a request and checks its address against the scoreboard.
  task automatic wait_req(output logic [63:0] exp_a, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("req_seen", 64'(seen), 64'd1);
    exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : '1;
    check_val("req_addr", imem_addr, exp_a);
  endtask

  task automatic fetch(input logic [31:0] word, input int delay);
    logic [63:0] exp_a;
    bit          seen;
    fetch_t      ent;
    wait_req(exp_a, seen);
    if (!seen) return;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check_val("wait_req", 64'(imem_req), 64'd1);
      check_val("wait_addr", imem_addr, exp_a);
      check_val("wait_valid", 64'(inst_valid), 64'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    sb_q.push_back('{addr: exp_a, word: word});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check_val("inst_valid", 64'(inst_valid), 64'd1);
    check_val("issue_req", 64'(imem_req), 64'd0);
    if (sb_q.size() > 0) begin
      ent = sb_q.pop_front();
      check_val("inst", 64'(inst), 64'(ent.word));
      check_val("pc_out", pc_out, ent.addr);
    end
  endtask

  task automatic accept(input logic b, input logic bz, input logic bnz, input logic az,
                        input logic [63:0] exp_next);
    exp_addr_q.push_back(exp_next);
    inst_accept    = 1'b1;
    branch         = b;
    branch_zero    = bz;
    branch_nonzero = bnz;
    alu_zero       = az;
    @(negedge clk);
    inst_accept    = 1'b0;
    branch         = 1'b0;
    branch_zero    = 1'b0;
    branch_nonzero = 1'b0;
    alu_zero       = 1'b0;
    check_val("valid_drop", 64'(inst_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] exp_a;
    bit          seen;

    reset          = 1'b1;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    inst_accept    = 1'b0;
    branch         = 1'b0;
    branch_zero    = 1'b0;
    branch_nonzero = 1'b0;
    alu_zero       = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_req", 64'(imem_req), 64'd0);
    check_val("rst_addr", imem_addr, 64'h0);
    check_val("rst_valid", 64'(inst_valid), 64'd0);
    check_val("rst_inst", 64'(inst), 64'd0);
    check_val("rst_pc_out", pc_out, 64'h0);
    check_val("rst_halted", 64'(halted), 64'd0);
    reset = 1'b0;
    exp_addr_q.push_back(64'h0);

    // Zero-latency ack, then a delayed ack with a spurious ack during issue.
    fetch(32'h8B020020, 0);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 64'h4);
    fetch(32'h8B1F03E0, 3);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check_val("spur_inst", 64'(inst), 64'h8B1F03E0);
    check_val("spur_valid", 64'(inst_valid), 64'd1);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 64'h8);
    fetch(32'h8B1F03E0, 0);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 64'hC);
    fetch(32'h8B1F03E0, 1);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 64'h10);

    // Unconditional branches, backward and forward.
    fetch(32'h17FFFFFE, 0);
    accept(1'b1, 1'b0, 1'b0, 1'b0, 64'h08);
    fetch(32'h14000006, 0);
    accept(1'b1, 1'b0, 1'b0, 1'b0, 64'h20);

    // CBZ / CBNZ with imm19 = 3 at pc 0x20.
    fetch(32'hB4000060, 0);
    accept(1'b0, 1'b1, 1'b0, 1'b1, 64'h2C);
    fetch(32'h17FFFFFD, 0);
    accept(1'b1, 1'b0, 1'b0, 1'b0, 64'h20);
    fetch(32'hB4000060, 2);
    accept(1'b0, 1'b1, 1'b0, 1'b0, 64'h24);
    fetch(32'h17FFFFFF, 0);
    accept(1'b1, 1'b0, 1'b0, 1'b0, 64'h20);
    fetch(32'hB5000060, 0);
    accept(1'b0, 1'b0, 1'b1, 1'b1, 64'h24);
    fetch(32'h17FFFFFF, 0);
    accept(1'b1, 1'b0, 1'b0, 1'b0, 64'h20);
    fetch(32'hB5000060, 0);
    accept(1'b0, 1'b0, 1'b1, 1'b0, 64'h2C);

    // Branch to self, then forward to 0x40.
    fetch(32'h14000000, 0);
    accept(1'b1, 1'b0, 1'b0, 1'b0, 64'h2C);
    fetch(32'h14000005, 0);
    accept(1'b1, 1'b0, 1'b0, 1'b0, 64'h40);

    // Reset while waiting at 0x40; the late ack must be discarded.
    wait_req(exp_a, seen);
    @(negedge clk);
    check_val("wait40_req", 64'(imem_req), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h8B020020;
    check_val("rst2_req", 64'(imem_req), 64'd0);
    check_val("rst2_addr", imem_addr, 64'h0);
    check_val("rst2_valid", 64'(inst_valid), 64'd0);
    check_val("rst2_inst", 64'(inst), 64'd0);
    check_val("rst2_pc_out", pc_out, 64'h0);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check_val("rst2_ack_drop", 64'(inst_valid), 64'd0);
    exp_addr_q.push_back(64'h0);

    // HALT: sticky, no further requests, accept ignored.
    fetch(32'hFFE00000, 1);
    @(negedge clk);
    check_val("halted", 64'(halted), 64'd1);
    check_val("halt_valid", 64'(inst_valid), 64'd0);
    inst_accept = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("halt_req", 64'(imem_req), 64'd0);
    end
    inst_accept = 1'b0;
    check_val("halt_sticky", 64'(halted), 64'd1);
    check_val("halt_valid2", 64'(inst_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
